// File: rtl/intreqw_pkg.sv
// Shared constants and FSM state type for the INTREQ write interceptor.
package intreqw_pkg;

  localparam logic [31:0] INTREQ_ADDR = 32'h00DF_F09C;
  localparam logic [31:0] INTENA_ADDR = 32'h00DF_F09A;

  localparam int unsigned SETCLR = 15;
  localparam int unsigned INTEN  = 14;
  localparam int unsigned PORTS  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StCapture,
    StHold
  } state_e;

endpackage

// File: rtl/intreqw_ide_int_sync.sv
// Two-flop synchronizer for the raw IDE INTRQ line with a rising-edge detector.
module ide_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3_q only remembers the previous synchronized level for edge detection.
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/intreqw.sv
// Snoops CPU writes to INTREQ and maintains the IDE pending latch and INT2 output.
// Define INTENA_SHADOW_EN to also track INTENA (INTEN/PORTS) and gate INT2 with it.
module intreqw
  import intreqw_pkg::*;
#(
  parameter int unsigned DTACK_SAMPLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [15:0] D,
  input  logic        AS20,
  input  logic        RW20,
  input  logic        DTACK,
  input  logic        IDEINT,
  output logic        INT2,
  output logic        PENDING,
  output logic        WRCYCLE
);

  localparam logic [2:0] DtackLast = 3'(DTACK_SAMPLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       int2_q;
  logic       ide_rise;
  logic       hit_intreq, hit_intena;
  logic       capture, cap_intreq;
  logic       int_cond;
  logic       unused_bits;

  assign unused_bits = ^{A[0], D[14:4], D[2:0]};

  ide_int_sync u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (IDEINT),
    .rise     (ide_rise)
  );

  assign hit_intreq = (A[31:1] == INTREQ_ADDR[31:1]) && !AS20 && !RW20;
`ifdef INTENA_SHADOW_EN
  assign hit_intena = (A[31:1] == INTENA_ADDR[31:1]) && !AS20 && !RW20;
`else
  assign hit_intena = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hit_intreq || hit_intena) begin
          state_d = StWaitAck;
          cnt_d   = '0;
        end
      end
      StWaitAck: begin
        // A released strobe aborts before any DTACK sample is considered.
        if (AS20) begin
          state_d = StIdle;
        end else if (!DTACK) begin
          if (cnt_q == DtackLast) state_d = StCapture;
          else                    cnt_d   = cnt_q + 3'd1;
        end else begin
          cnt_d = '0;
        end
      end
      StCapture: state_d = StHold;
      StHold:    if (AS20) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign capture = (state_q == StCapture);

`ifdef INTENA_SHADOW_EN
  logic tgt_ena_q, inten_q, inten_d, ports_q, ports_d;

  always_comb begin
    inten_d = inten_q;
    ports_d = ports_q;
    if (capture && tgt_ena_q) begin
      if (D[INTEN]) inten_d = D[SETCLR];
      if (D[PORTS]) ports_d = D[SETCLR];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tgt_ena_q <= 1'b0;
      inten_q   <= 1'b0;
      ports_q   <= 1'b0;
    end else begin
      if (state_q == StIdle) tgt_ena_q <= hit_intena;
      inten_q <= inten_d;
      ports_q <= ports_d;
    end
  end

  assign cap_intreq = capture & ~tgt_ena_q;
  assign int_cond   = pending_q & ports_q & inten_q;
`else
  assign cap_intreq = capture;
  assign int_cond   = pending_q;
`endif

  always_comb begin
    pending_d = pending_q;
    if (cap_intreq && D[PORTS]) pending_d = D[SETCLR];
    // A fresh IDE edge wins over a simultaneous software clear.
    if (ide_rise) pending_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= 1'b0;
      int2_q    <= 1'b1;
    end else begin
      pending_q <= pending_d;
      int2_q    <= ~int_cond;
    end
  end

  assign PENDING = pending_q;
  assign INT2    = int2_q;
  assign WRCYCLE = capture;

endmodule

// File: tb/tb_intreqw.sv
// Directed self-checking bench for intreqw (DTACK_SAMPLES = 2).
module tb_intreqw;

  logic        CLK, RESET;
  logic [31:0] A;
  logic [15:0] D;
  logic        AS20, RW20, DTACK, IDEINT;
  logic        INT2, PENDING, WRCYCLE;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int w0;

  localparam logic [31:0] AddrReq = 32'h00DF_F09C;
  localparam logic [31:0] AddrEna = 32'h00DF_F09A;

`ifdef INTENA_SHADOW_EN
  localparam logic [31:0] EnaWr   = 32'd1;
  localparam logic [31:0] Int2Off = 32'd1;
`else
  localparam logic [31:0] EnaWr   = 32'd0;
  localparam logic [31:0] Int2Off = 32'd0;
`endif

  intreqw #(.DTACK_SAMPLES(2)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .A       (A),
    .D       (D),
    .AS20    (AS20),
    .RW20    (RW20),
    .DTACK   (DTACK),
    .IDEINT  (IDEINT),
    .INT2    (INT2),
    .PENDING (PENDING),
    .WRCYCLE (WRCYCLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (WRCYCLE === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_start(input logic [31:0] addr, input logic [15:0] data);
    A = addr; D = data; RW20 = 1'b0; AS20 = 1'b0; DTACK = 1'b1;
    step(1);
  endtask

  task automatic bus_end();
    AS20 = 1'b1; DTACK = 1'b1; RW20 = 1'b1;
  endtask

  // Full write: two DTACK-low samples, capture, hold, then strobe release.
  task automatic bus_write(input logic [31:0] addr, input logic [15:0] data);
    bus_start(addr, data);
    DTACK = 1'b0;
    step(3);
    bus_end();
    step(1);
  endtask

  initial begin
    A = '0; D = '0; AS20 = 1'b1; RW20 = 1'b1; DTACK = 1'b1; IDEINT = 1'b0;
    RESET = 1'b1;
    step(2);
    check("rst_pending", 32'(PENDING), 32'd0);
    check("rst_int2",    32'(INT2),    32'd1);
    check("rst_wrcycle", 32'(WRCYCLE), 32'd0);
    RESET = 1'b0;
    step(1);
`ifdef INTENA_SHADOW_EN
    bus_write(AddrEna, 16'hC008);
`endif

    // IDE edge through the synchronizer
    IDEINT = 1'b1;
    step(2);
    check("ide_not_yet", 32'(PENDING), 32'd0);
    step(1);
    check("ide_pending", 32'(PENDING), 32'd1);
    check("ide_int2_lag", 32'(INT2), 32'd1);
    step(1);
    check("ide_int2", 32'(INT2), 32'd0);

    // Clear with 0x0008
    w0 = wr_cnt;
    bus_write(AddrReq, 16'h0008);
    check("clr_wrcycle", 32'(wr_cnt - w0), 32'd1);
    check("clr_pending", 32'(PENDING), 32'd0);
    check("clr_int2",    32'(INT2),    32'd1);

    // Software set with 0x8008
    IDEINT = 1'b0;
    step(3);
    w0 = wr_cnt;
    bus_write(AddrReq, 16'h8008);
    check("set_wrcycle", 32'(wr_cnt - w0), 32'd1);
    check("set_pending", 32'(PENDING), 32'd1);
    check("set_int2",    32'(INT2),    32'd0);

    // PORTS bit clear: no effect
    bus_write(AddrReq, 16'h0004);
    check("noport_pending", 32'(PENDING), 32'd1);

    // Read cycle is ignored
    w0 = wr_cnt;
    A = AddrReq; D = 16'h0008; RW20 = 1'b1; AS20 = 1'b0; DTACK = 1'b0;
    step(5);
    bus_end();
    step(1);
    check("read_wrcycle", 32'(wr_cnt - w0), 32'd0);
    check("read_pending", 32'(PENDING), 32'd1);

    // Non-matching address
    w0 = wr_cnt;
    bus_write(32'h00DF_F09E, 16'h0008);
    check("miss_wrcycle", 32'(wr_cnt - w0), 32'd0);
    check("miss_pending", 32'(PENDING), 32'd1);

    // INTENA write: captured only with the shadow built
    w0 = wr_cnt;
    bus_write(AddrEna, 16'h8008);
    check("ena_wrcycle", 32'(wr_cnt - w0), EnaWr);
    check("ena_pending", 32'(PENDING), 32'd1);
    check("ena_int2",    32'(INT2),    32'd0);

    // Abort after one DTACK-low sample
    w0 = wr_cnt;
    bus_start(AddrReq, 16'h0008);
    DTACK = 1'b0;
    step(1);
    bus_end();
    step(3);
    check("abort_wrcycle", 32'(wr_cnt - w0), 32'd0);
    check("abort_pending", 32'(PENDING), 32'd1);

    // High DTACK sample restarts the count
    w0 = wr_cnt;
    bus_start(AddrReq, 16'h0008);
    DTACK = 1'b0; step(1);
    DTACK = 1'b1; step(1);
    DTACK = 1'b0; step(1);
    check("restart_early", 32'(WRCYCLE), 32'd0);
    step(1);
    check("restart_cap", 32'(WRCYCLE), 32'd1);
    step(1);
    check("restart_pulse", 32'(WRCYCLE), 32'd0);
    check("restart_pending", 32'(PENDING), 32'd0);
    bus_end();
    step(1);
    check("restart_count", 32'(wr_cnt - w0), 32'd1);
    check("restart_int2", 32'(INT2), 32'd1);

    // Clear coinciding with a synchronized IDE edge
    bus_write(AddrReq, 16'h8008);
    w0 = wr_cnt;
    bus_start(AddrReq, 16'h0008);
    DTACK = 1'b0; IDEINT = 1'b1;
    step(3);
    check("race_pending", 32'(PENDING), 32'd1);
    bus_end();
    step(1);
    check("race_hold", 32'(PENDING), 32'd1);
    check("race_int2", 32'(INT2), 32'd0);
    check("race_wrcycle", 32'(wr_cnt - w0), 32'd1);

    // Reset in the middle of a write
    IDEINT = 1'b0;
    step(4);
    w0 = wr_cnt;
    bus_start(AddrReq, 16'h8008);
    DTACK = 1'b0;
    step(1);
    RESET = 1'b1;
    #1;
    check("mid_rst_pending", 32'(PENDING), 32'd0);
    check("mid_rst_int2", 32'(INT2), 32'd1);
    bus_end();
    step(1);
    RESET = 1'b0;
    step(4);
    check("mid_rst_wrcycle", 32'(wr_cnt - w0), 32'd0);
    check("mid_rst_idle", 32'(PENDING), 32'd0);
`ifdef INTENA_SHADOW_EN
    bus_write(AddrEna, 16'hC008);
`endif
    bus_write(AddrReq, 16'h8008);
    check("post_rst_pending", 32'(PENDING), 32'd1);
    check("post_rst_int2", 32'(INT2), 32'd0);

    // INTENA enable then disable of INTEN
    bus_write(AddrEna, 16'hC008);
    check("ena_on_int2", 32'(INT2), 32'd0);
    bus_write(AddrEna, 16'h4000);
    check("ena_off_int2", 32'(INT2), Int2Off);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intreqw.md
INTREQW -- requirements
Module: intreqw

Interface
REQ-001 Parameter DTACK_SAMPLES, default 2: consecutive CLK samples of DTACK low required before data capture; legal range 1-4.
REQ-002 CLK  input  1  system clock; all sequential logic rises on CLK.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 A  input  32  CPU address bus.
REQ-005 D  input  16  CPU data bus; write data for even-word chipset writes.
REQ-006 AS20  input  1  CPU address strobe, active low.
REQ-007 RW20  input  1  CPU read/write; 0 means write.
REQ-008 DTACK  input  1  chipset data acknowledge, active low.
REQ-009 IDEINT  input  1  raw IDE INTRQ, active high, asynchronous to CLK.
REQ-010 INT2  output  1  registered level-2 interrupt request to the mainboard, active low.
REQ-011 PENDING  output  1  IDE interrupt pending latch, active high.
REQ-012 WRCYCLE  output  1  high for exactly one CLK when a qualifying write is captured.

Function
REQ-013 An INTREQ write SHALL be decoded when A[31:1] equals 0x00DFF09C>>1, AS20=0 and RW20=0.
REQ-014 IDEINT SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized level SHALL set PENDING on the next CLK.
REQ-015 The write FSM SHALL have the states IDLE, WAIT_ACK, CAPTURE and HOLD.
REQ-016 IDLE->WAIT_ACK when an INTREQ write is decoded.
REQ-017 WAIT_ACK->CAPTURE after DTACK is sampled low on DTACK_SAMPLES consecutive CLKs; a high sample restarts the count.
REQ-018 CAPTURE SHALL latch D, pulse WRCYCLE for one CLK, and go to HOLD on the next CLK.
REQ-019 HOLD->IDLE when AS20 is sampled high; no second capture SHALL occur in one bus cycle.
REQ-020 AS20 going high in WAIT_ACK SHALL abort the cycle: return to IDLE, no capture, no WRCYCLE, PENDING unchanged.
REQ-021 Captured D[15]=0 with D[3]=1 SHALL clear PENDING on the CLK after CAPTURE.
REQ-022 Captured D[15]=1 with D[3]=1 SHALL set PENDING on the CLK after CAPTURE (software set).
REQ-023 Captured D[3]=0 SHALL leave PENDING unchanged.
REQ-024 A clear and a synchronized IDEINT rising edge in the same CLK SHALL leave PENDING set, so no interrupt is lost.
REQ-025 INT2 SHALL equal the registered inverse of the interrupt condition, giving one CLK after PENDING changes.
REQ-026 Reads and accesses to non-matching addresses SHALL leave the FSM in IDLE with no effect.

Reset
REQ-027 While RESET is high: state=IDLE, PENDING=0, INT2=1, WRCYCLE=0, DTACK sample count=0, synchronizer flops=0, and INTENA shadow bits=0 when the shadow is built.
REQ-028 RESET asserted mid-cycle SHALL discard any capture in progress; after release the FSM SHALL wait in IDLE for a new decoded write.

Configuration
REQ-029 Macro INTENA_SHADOW_EN defined: the FSM SHALL also decode writes to 0x00DFF09A.
REQ-030 With INTENA_SHADOW_EN, captured D[15]=1 SHALL set shadow bits INTEN (D[14]) and PORTS (D[3]) where the data bit is 1; D[15]=0 SHALL clear them where the data bit is 1.
REQ-031 With INTENA_SHADOW_EN, the interrupt condition SHALL be PENDING AND PORTS AND INTEN.
REQ-032 Macro INTENA_SHADOW_EN undefined: INTENA writes SHALL be ignored and the interrupt condition SHALL be PENDING alone.

Structure
REQ-033 A shared package SHALL hold: INTREQ_ADDR (0x00DFF09C), INTENA_ADDR (0x00DFF09A), bit indices SETCLR=15, INTEN=14, PORTS=3, and the FSM state enum.
REQ-034 The 2-flop synchronizer plus rising-edge detector SHALL be one sub-module, ide_int_sync; the rest SHALL be flat in intreqw.

Verification
REQ-035 IDEINT 0->1 -> PENDING=1 within 3 CLKs; INT2=0 one CLK later.
REQ-036 PENDING=1, CPU writes 0x0008 to DFF09C, DTACK low for 2 CLKs -> WRCYCLE pulses once; PENDING=0 and INT2=1 within 2 CLKs of capture.
REQ-037 CPU writes 0x8008 to DFF09C with IDEINT low -> PENDING=1 and INT2=0.
REQ-038 AS20 rises after one DTACK-low sample (DTACK_SAMPLES=2) -> no WRCYCLE and PENDING unchanged.
REQ-039 Clear capture coincides with a synchronized IDEINT rising edge -> PENDING remains 1.
REQ-040 With INTENA_SHADOW_EN and PENDING=1, write 0xC008 to DFF09A -> INT2=0; then write 0x4000 -> INT2=1.
